// File: rtl/common_pseudo_lru_victim_alloc.sv
// ---------------------------------------------------------------------------
// common_pseudo_lru_victim_alloc
//
// This block sits between a cache controller and its pseudo-LRU. It does two
// jobs:
//   * Hit touches: it forwards each hit to the pseudo-LRU touch port in the
//     same cycle (zero latency).
//   * Miss allocation: it captures the LRU victim and hands it to the refill
//     engine. When the refill completes, it touches that way as most recently
//     used. Only one miss can be outstanding at a time.
//
// Parameters
//   SUBJECT_COUNT_LOG2 : log2 of the way count. P_COUNT = 1 << SUBJECT_COUNT_LOG2.
//
// Ports
//   clk, reset     : single clock; synchronous active-high reset
//   lru_qaddr      : one-hot victim suggested by the pseudo-LRU
//   lru_waddr      : binary way to touch in the pseudo-LRU
//   lru_wen        : touch strobe to the pseudo-LRU
//   hit_valid      : hit-touch request (valid)
//   hit_way        : hit-touch request (way to touch)
//   hit_ready      : hit-touch request (ready)
//   miss_valid     : allocation request (valid)
//   miss_ready     : allocation request (ready)
//   victim_valid   : allocated victim for the refill engine (valid)
//   victim_way     : allocated victim for the refill engine (way)
//   victim_ready   : allocated victim for the refill engine (ready)
//   refill_done    : one-cycle pulse; the refill of victim_way has finished
// ---------------------------------------------------------------------------
module common_pseudo_lru_victim_alloc #(
    parameter  int SUBJECT_COUNT_LOG2 = 1,
    localparam int P_COUNT            = 1 << SUBJECT_COUNT_LOG2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [P_COUNT-1:0]            lru_qaddr,
    output logic [SUBJECT_COUNT_LOG2-1:0] lru_waddr,
    output logic                          lru_wen,
    input  logic                          hit_valid,
    input  logic [SUBJECT_COUNT_LOG2-1:0] hit_way,
    output logic                          hit_ready,
    input  logic                          miss_valid,
    output logic                          miss_ready,
    output logic                          victim_valid,
    output logic [SUBJECT_COUNT_LOG2-1:0] victim_way,
    input  logic                          victim_ready,
    input  logic                          refill_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALLOC  = 2'd1,
        ST_REFILL = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t                          state_q;
    state_t                          state_d;
    state_t                          state_view;
    logic [SUBJECT_COUNT_LOG2-1:0]   victim_way_q;
    logic [SUBJECT_COUNT_LOG2-1:0]   victim_way_d;

    // Lowest-index-set-bit priority select on lru_qaddr.
    // lower_seen[gi] is high when any bit below gi is set.
    logic [P_COUNT-1:0]              lower_seen;
    logic [P_COUNT-1:0]              first_hot;
    logic [SUBJECT_COUNT_LOG2-1:0]   qaddr_enc;

    generate
        for (genvar gi = 0; gi < P_COUNT; gi++) begin : g_prio
            if (gi == 0) begin : g_first
                assign lower_seen[gi] = 1'b0;
            end else begin : g_rest
                assign lower_seen[gi] = lower_seen[gi-1] | lru_qaddr[gi-1];
            end
            assign first_hot[gi] = lru_qaddr[gi] & ~lower_seen[gi];
        end
    endgenerate

    // first_hot has at most one bit set, so OR-ing the indices yields the
    // binary encoding. An all-zero input leaves the result at way 0.
    always_comb begin
        qaddr_enc = '0;
        for (int i = 0; i < P_COUNT; i++) begin
            if (first_hot[i]) begin
                qaddr_enc = qaddr_enc | SUBJECT_COUNT_LOG2'(i);
            end
        end
    end

    // While reset is held, the outputs behave as in IDLE. This keeps a
    // pending COMMIT from touching the LRU during the reset cycle itself.
    assign state_view = reset ? ST_IDLE : state_q;

    always_comb begin
        miss_ready   = (state_view == ST_IDLE);
        victim_valid = (state_view == ST_ALLOC);
        hit_ready    = (state_view != ST_COMMIT);
        victim_way   = victim_way_q;
        lru_wen      = 1'b0;
        lru_waddr    = '0;
        if (state_view == ST_COMMIT) begin
            // The commit touch wins. The hit is held off through hit_ready.
            lru_wen   = 1'b1;
            lru_waddr = victim_way_q;
        end else if (hit_valid) begin
            lru_wen   = 1'b1;
            lru_waddr = hit_way;
        end
    end

    always_comb begin
        state_d      = state_q;
        victim_way_d = victim_way_q;
        unique case (state_q)
            ST_IDLE: begin
                if (miss_valid) begin
                    victim_way_d = qaddr_enc;
                    state_d      = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                if (victim_ready) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (refill_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            victim_way_q <= '0;
        end else begin
            state_q      <= state_d;
            victim_way_q <= victim_way_d;
        end
    end

endmodule

// File: tb/tb_common_pseudo_lru_victim_alloc.sv
// ---------------------------------------------------------------------------
// Testbench for common_pseudo_lru_victim_alloc (4 ways).
//
// A driver process applies the inputs for each cycle. A reference model then
// computes the outputs expected in that cycle and pushes them into a
// scoreboard queue. A separate monitor pops the queue on every falling edge
// and compares the popped values with the DUT outputs.
//
// In "lru mode", lru_qaddr comes from a true-LRU age list. The bench updates
// that list from the model's own expected touches, so the stimulus never
// depends on what the DUT did.
// ---------------------------------------------------------------------------
module tb_common_pseudo_lru_victim_alloc;

    localparam int L2 = 2;
    localparam int N  = 1 << L2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  lru_qaddr;
    logic [L2-1:0] lru_waddr;
    logic          lru_wen;
    logic          hit_valid;
    logic [L2-1:0] hit_way;
    logic          hit_ready;
    logic          miss_valid;
    logic          miss_ready;
    logic          victim_valid;
    logic [L2-1:0] victim_way;
    logic          victim_ready;
    logic          refill_done;

    always #5 clk = ~clk;

    common_pseudo_lru_victim_alloc #(.SUBJECT_COUNT_LOG2(L2)) dut (
        .clk          (clk),
        .reset        (reset),
        .lru_qaddr    (lru_qaddr),
        .lru_waddr    (lru_waddr),
        .lru_wen      (lru_wen),
        .hit_valid    (hit_valid),
        .hit_way      (hit_way),
        .hit_ready    (hit_ready),
        .miss_valid   (miss_valid),
        .miss_ready   (miss_ready),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .victim_ready (victim_ready),
        .refill_done  (refill_done)
    );

    typedef struct {
        int cyc;
        int miss_ready;
        int hit_ready;
        int victim_valid;
        int victim_way;
        int lru_wen;
        int lru_waddr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   use_lru  = 1'b0;
    int   lru_order[$];

    // Model state.
    //   m_phase  : 0 = no miss pending
    //              1 = victim offered to the refill engine
    //              2 = refill in progress
    //              3 = commit touch
    //   m_victim : the way currently presented on victim_way
    int   m_phase  = 0;
    int   m_victim = 0;

    task automatic chk(input int c, input string nm, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, c, act, exp);
        end
    endtask

    function automatic int lowest_way(input int q);
        for (int i = 0; i < N; i++) begin
            if (((q >> i) & 1) == 1) return i;
        end
        return 0;
    endfunction

    task automatic lru_touch(input int w);
        for (int i = 0; i < lru_order.size(); i++) begin
            if (lru_order[i] == w) begin
                lru_order.delete(i);
                break;
            end
        end
        lru_order.push_back(w);
    endtask

    // One clock cycle: build the expectation for the inputs now applied,
    // advance the model, then move to just after the next rising edge.
    task automatic tick();
        exp_t e;
        int   eff;
        if (use_lru) lru_qaddr = N'(1 << lru_order[0]);
        eff            = reset ? 0 : m_phase;
        e.cyc          = cyc;
        e.miss_ready   = (eff == 0) ? 1 : 0;
        e.hit_ready    = (eff != 3) ? 1 : 0;
        e.victim_valid = (eff == 1) ? 1 : 0;
        e.victim_way   = m_victim;
        if (eff == 3) begin
            e.lru_wen   = 1;
            e.lru_waddr = m_victim;
        end else if (hit_valid) begin
            e.lru_wen   = 1;
            e.lru_waddr = int'(hit_way);
        end else begin
            e.lru_wen   = 0;
            e.lru_waddr = 0;
        end
        exp_q.push_back(e);
        if (e.lru_wen == 1) lru_touch(e.lru_waddr);
        if (reset) begin
            m_phase  = 0;
            m_victim = 0;
        end else begin
            case (m_phase)
                0: if (miss_valid) begin
                       m_victim = lowest_way(int'(lru_qaddr));
                       m_phase  = 1;
                   end
                1: if (victim_ready) m_phase = 2;
                2: if (refill_done)  m_phase = 3;
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic quiet();
        reset        = 1'b0;
        miss_valid   = 1'b0;
        hit_valid    = 1'b0;
        hit_way      = '0;
        victim_ready = 1'b0;
        refill_done  = 1'b0;
    endtask

    // Run one miss along the minimum-latency path, then one idle cycle.
    task automatic run_miss(input logic [N-1:0] qa);
        lru_qaddr  = qa;
        miss_valid = 1'b1;
        tick();
        miss_valid   = 1'b0;
        victim_ready = 1'b1;
        tick();
        victim_ready = 1'b0;
        refill_done  = 1'b1;
        tick();
        refill_done = 1'b0;
        tick();
        tick();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.cyc, "miss_ready",   32'(miss_ready),   e.miss_ready);
            chk(e.cyc, "hit_ready",    32'(hit_ready),    e.hit_ready);
            chk(e.cyc, "victim_valid", 32'(victim_valid), e.victim_valid);
            chk(e.cyc, "victim_way",   32'(victim_way),   e.victim_way);
            chk(e.cyc, "lru_wen",      32'(lru_wen),      e.lru_wen);
            chk(e.cyc, "lru_waddr",    32'(lru_waddr),    e.lru_waddr);
        end
    end

    initial begin
        lru_order = {0, 1, 2, 3};
        quiet();
        lru_qaddr = '0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        // Reset held, first with a hit presented and then without one.
        hit_valid = 1'b1;
        hit_way   = 2'd2;
        tick();
        hit_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Victim 2 from one-hot 0100; commit touch lands exactly at T+3.
        run_miss(4'b0100);

        // All-zero encodes to way 0; 1010 selects the lowest set bit (way 1).
        run_miss(4'b0000);
        run_miss(4'b1010);

        // A hit to way 3 is held across the COMMIT of victim 1.
        lru_qaddr  = 4'b0010;
        miss_valid = 1'b1;
        tick();
        miss_valid   = 1'b0;
        victim_ready = 1'b1;
        tick();
        victim_ready = 1'b0;
        refill_done  = 1'b1;
        hit_valid    = 1'b1;
        hit_way      = 2'd3;
        tick();
        refill_done = 1'b0;
        tick();
        tick();
        hit_valid = 1'b0;
        tick();

        // The refill engine stalls for 5 cycles while lru_qaddr toggles.
        lru_qaddr  = 4'b1000;
        miss_valid = 1'b1;
        tick();
        repeat (5) begin
            lru_qaddr = N'($urandom);
            tick();
        end
        miss_valid   = 1'b0;
        victim_ready = 1'b1;
        tick();
        victim_ready = 1'b0;
        refill_done  = 1'b1;
        tick();
        refill_done = 1'b0;
        tick();
        tick();

        // Reset arrives during REFILL; the later refill_done must be ignored.
        lru_qaddr  = 4'b0100;
        miss_valid = 1'b1;
        tick();
        miss_valid   = 1'b0;
        victim_ready = 1'b1;
        tick();
        victim_ready = 1'b0;
        reset        = 1'b1;
        tick();
        reset       = 1'b0;
        refill_done = 1'b1;
        tick();
        refill_done = 1'b0;
        tick();
        tick();

        // Back-to-back misses fed by an LRU that follows the commit touches.
        use_lru      = 1'b1;
        lru_order    = {0, 1, 2, 3};
        miss_valid   = 1'b1;
        victim_ready = 1'b1;
        refill_done  = 1'b1;
        repeat (13) tick();
        quiet();
        tick();

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            use_lru      = ($urandom_range(0, 1) == 1);
            reset        = ($urandom_range(0, 49) == 0);
            miss_valid   = ($urandom_range(0, 2) == 0);
            hit_valid    = ($urandom_range(0, 1) == 1);
            hit_way      = L2'($urandom);
            victim_ready = ($urandom_range(0, 1) == 1);
            refill_done  = ($urandom_range(0, 2) == 0);
            if (!use_lru) lru_qaddr = N'($urandom);
            tick();
        end
        quiet();
        tick();

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
